// File: rtl/uart_frame_collector.sv
// UART 8N1 receiver that reassembles NBYTES consecutive bytes (LSB byte first)
// into one frame word with a valid/ready handshake. Flags framing errors,
// inter-byte timeouts and frames dropped because the consumer was not ready.
module uart_frame_collector #(
  parameter int CLK_FREQ     = 10000000,
  parameter int BAUD         = 115200,
  parameter int NBYTES       = 3,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                rx_line,
  output logic [8*NBYTES-1:0] frame_data,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                byte_strobe,
  output logic                frame_err,
  output logic [1:0]          err_code,
  output logic                overrun
);

  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int TW       = $clog2(CPB + 1);
  localparam int TO_LIMIT = TIMEOUT_BITS * CPB;
  localparam int OW       = $clog2(TO_LIMIT + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(CPB / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CPB - 1);
  localparam logic [OW-1:0] TO_LAST   = OW'(TO_LIMIT - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t              state_r;
  logic                rx_meta_r;
  logic                rxs_r;
  logic [TW-1:0]       bit_timer_r;
  logic [2:0]          bit_cnt_r;
  logic [7:0]          shreg_r;
  logic [2:0]          byte_idx_r;
  logic [OW-1:0]       idle_timer_r;
  logic [8*NBYTES-1:0] asm_r;
  logic [8*NBYTES-1:0] frame_next_s;
  logic                accept_s;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
    end else begin
      rx_meta_r <= rx_line;
      rxs_r     <= rx_meta_r;
    end
  end

  // Completed frame: earlier bytes from the assembly buffer, the byte just received on top.
  always_comb begin
    frame_next_s = asm_r;
    frame_next_s[8*(NBYTES-1) +: 8] = shreg_r;
    accept_s = frame_valid & frame_ready;
  end

  // Receiver FSM, frame assembly, timeout and output registers.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      bit_timer_r  <= '0;
      bit_cnt_r    <= 3'd0;
      shreg_r      <= 8'h00;
      byte_idx_r   <= 3'd0;
      idle_timer_r <= '0;
      asm_r        <= '0;
      frame_data   <= '0;
      frame_valid  <= 1'b0;
      byte_strobe  <= 1'b0;
      frame_err    <= 1'b0;
      err_code     <= 2'd0;
      overrun      <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
      // A consumed frame is released; a frame completing this cycle overrides it below.
      if (accept_s) begin
        frame_valid <= 1'b0;
      end
      case (state_r)
        S_IDLE: begin
          if (!rxs_r) begin
            state_r      <= S_START;
            bit_timer_r  <= '0;
            idle_timer_r <= '0;
          end else if (byte_idx_r != 3'd0) begin
            // Partial frame waiting for its next byte.
            if (idle_timer_r == TO_LAST) begin
              byte_idx_r   <= 3'd0;
              idle_timer_r <= '0;
              frame_err    <= 1'b1;
              err_code     <= 2'd2;
            end else begin
              idle_timer_r <= idle_timer_r + OW'(1);
            end
          end
        end
        S_START: begin
          if (bit_timer_r == HALF_LAST) begin
            bit_timer_r <= '0;
            bit_cnt_r   <= 3'd0;
            // A line already back high at mid start bit is a glitch and is ignored.
            state_r     <= rxs_r ? S_IDLE : S_DATA;
          end else begin
            bit_timer_r <= bit_timer_r + TW'(1);
          end
        end
        S_DATA: begin
          if (bit_timer_r == BIT_LAST) begin
            bit_timer_r <= '0;
            shreg_r     <= {rxs_r, shreg_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              state_r <= S_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            bit_timer_r <= bit_timer_r + TW'(1);
          end
        end
        S_STOP: begin
          if (bit_timer_r == BIT_LAST) begin
            bit_timer_r <= '0;
            if (rxs_r) begin
              byte_strobe <= 1'b1;
              state_r     <= S_IDLE;
              if (byte_idx_r == LAST_IDX) begin
                byte_idx_r <= 3'd0;
                if (!frame_valid || accept_s) begin
                  frame_data  <= frame_next_s;
                  frame_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                asm_r[{byte_idx_r, 3'b000} +: 8] <= shreg_r;
                byte_idx_r <= byte_idx_r + 3'd1;
              end
            end else begin
              byte_idx_r <= 3'd0;
              frame_err  <= 1'b1;
              err_code   <= 2'd1;
              state_r    <= S_BREAK;
            end
          end else begin
            bit_timer_r <= bit_timer_r + TW'(1);
          end
        end
        S_BREAK: begin
          if (rxs_r) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_collector.sv
// Self-checking bench for uart_frame_collector: directed scenarios plus random
// frames with small baud mismatch, checked against a byte/frame-level model.
module tb_uart_frame_collector;

  localparam int NB  = 3;
  localparam int CPB = 86;

  logic            clk1;
  logic            rst_n;
  logic            rx_line;
  logic [8*NB-1:0] frame_data;
  logic            frame_valid;
  logic            frame_ready;
  logic            byte_strobe;
  logic            frame_err;
  logic [1:0]      err_code;
  logic            overrun;

  uart_frame_collector #(
    .CLK_FREQ(10000000), .BAUD(115200), .NBYTES(NB), .TIMEOUT_BITS(20)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .rx_line(rx_line),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .byte_strobe(byte_strobe), .frame_err(frame_err), .err_code(err_code),
    .overrun(overrun)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;

  // Reference model state: bytes of the frame in progress, expected frames/pulses.
  logic [7:0]  part_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          exp_strobes = 0, got_strobes = 0;
  int          exp_errs = 0, got_errs = 0;
  logic [1:0]  exp_code = 2'd0;
  logic        exp_over = 1'b0;
  bit          hold_mode = 1'b0;
  bit          held_valid = 1'b0;
  logic [31:0] held_frame = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe DUT outputs away from the active edge.
  always @(negedge clk1) begin
    if (byte_strobe) got_strobes++;
    if (frame_err) got_errs++;
    if (frame_valid && frame_ready) got_q.push_back(32'(frame_data));
  end

  task automatic m_byte(input logic [7:0] b);
    logic [31:0] f;
    exp_strobes++;
    part_q.push_back(b);
    if (part_q.size() == NB) begin
      f = 32'h0;
      for (int k = 0; k < NB; k++) f = f | (32'(part_q[k]) << (8 * k));
      part_q.delete();
      if (!hold_mode) exp_q.push_back(f);
      else if (!held_valid) begin held_valid = 1'b1; held_frame = f; end
      else exp_over = 1'b1;
    end
  endtask

  task automatic m_abort(input logic [1:0] code);
    part_q.delete();
    exp_errs++;
    exp_code = code;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int clks, input logic stop_bit);
    rx_line = 1'b0;
    wait_cycles(clks);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      wait_cycles(clks);
    end
    rx_line = stop_bit;
    wait_cycles(clks);
    rx_line = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b, input int clks);
    send_byte(b, clks, 1'b1);
    m_byte(b);
  endtask

  task automatic scen_check(input string tag);
    wait_cycles(20);
    chk({tag, "_strobes"}, 32'(got_strobes), 32'(exp_strobes));
    chk({tag, "_errs"}, 32'(got_errs), 32'(exp_errs));
    chk({tag, "_code"}, 32'(err_code), 32'(exp_code));
    chk({tag, "_overrun"}, 32'(overrun), 32'(exp_over));
    chk({tag, "_nframes"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_frame"}, got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    rst_n = 1'b0;
    rx_line = 1'b1;
    frame_ready = 1'b1;
    wait_cycles(3);
    chk("rst_valid", 32'(frame_valid), 32'h0);
    chk("rst_data", 32'(frame_data), 32'h0);
    chk("rst_strobe", 32'(byte_strobe), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    chk("rst_code", 32'(err_code), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    wait_cycles(10);

    // 1: basic frame
    send_good(8'h34, CPB);
    send_good(8'h12, CPB);
    send_good(8'hAB, CPB);
    scen_check("t1");

    // 2: start-bit glitch
    rx_line = 1'b0;
    wait_cycles(20);
    rx_line = 1'b1;
    wait_cycles(200);
    scen_check("t2");

    // 3: framing error then a clean frame
    send_byte(8'h55, CPB, 1'b0);
    m_abort(2'd1);
    wait_cycles(10);
    scen_check("t3_err");
    for (int i = 0; i < NB; i++) send_good(8'($urandom_range(0, 255)), CPB);
    scen_check("t3_frame");

    // 4: inter-byte timeout
    send_good(8'h01, CPB);
    send_good(8'h02, CPB);
    wait_cycles(20 * CPB + 2 + 60);
    m_abort(2'd2);
    scen_check("t4_err");
    send_good(8'h0A, CPB);
    send_good(8'h0B, CPB);
    send_good(8'h0C, CPB);
    scen_check("t4_frame");

    // 5: consumer stalled across two frames
    frame_ready = 1'b0;
    hold_mode = 1'b1;
    for (int i = 0; i < 2 * NB; i++) send_good(8'($urandom_range(0, 255)), CPB);
    wait_cycles(20);
    chk("t5_valid", 32'(frame_valid), 32'h1);
    chk("t5_data", 32'(frame_data), held_frame);
    chk("t5_overrun", 32'(overrun), 32'(exp_over));
    frame_ready = 1'b1;
    wait_cycles(1);
    chk("t5_drop", 32'(frame_valid), 32'h0);
    exp_q.push_back(held_frame);
    hold_mode = 1'b0;
    held_valid = 1'b0;
    scen_check("t5");

    // 6: reset during bit 4 of the second byte
    send_good(8'h11, CPB);
    rx_line = 1'b0;
    wait_cycles(CPB);
    rx_line = 1'b1;
    wait_cycles(4 * CPB + CPB / 2);
    rst_n = 1'b0;
    wait_cycles(1);
    rst_n = 1'b1;
    part_q.delete();
    exp_code = 2'd0;
    exp_over = 1'b0;
    chk("t6_valid", 32'(frame_valid), 32'h0);
    chk("t6_code", 32'(err_code), 32'h0);
    chk("t6_overrun", 32'(overrun), 32'h0);
    wait_cycles(5 * CPB);
    send_good(8'h80, CPB);
    send_good(8'hFF, CPB);
    send_good(8'h00, CPB);
    chk("t6_frame_exp", exp_q.size() > 0 ? exp_q[0] : 32'h0, 32'h0000FF80);
    scen_check("t6");

    // Random frames with slightly fast/slow transmitters and random gaps.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NB; i++) begin
        b = 8'($urandom_range(0, 255));
        send_good(b, int'($urandom_range(CPB - 1, CPB + 1)));
        wait_cycles(int'($urandom_range(0, 150)));
      end
      scen_check("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
